// File: rtl/perf_pkg.sv
// rtl/perf_pkg.sv - shared constants for the performance-counter bank
package perf_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_FROZEN = 2'd2;

    localparam int EV_RETIRE = 0;
    localparam int EV_DHIT   = 1;
    localparam int EV_IHIT   = 2;
    localparam int EV_DREQ   = 3;
    localparam int EV_IREQ   = 4;
    localparam int EV_STALL  = 5;

    localparam int RD_CYCLE = 0;

endpackage

// File: rtl/perf_counter.sv
// rtl/perf_counter.sv - single saturating/wrapping event counter with sticky overflow
module perf_counter #(
    parameter int CNT_W    = 32,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             run_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_nxt_o,
    output logic             ovf_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (run_i && inc_i) begin
            if (&cnt_q) begin
                ovf_d = 1'b1;
                cnt_d = SATURATE ? cnt_q : '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Post-update value lets a snapshot include the increment of its own cycle.
    assign cnt_nxt_o = cnt_d;
    assign ovf_o     = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - cycle + event counter bank with run/freeze FSM and snapshot read port
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int NUM_EVENTS = 6,
    parameter int CNT_W      = 32,
    parameter bit SATURATE   = 1'b1,
    parameter int SEL_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  clr,
    input  logic                  halt,
    input  logic [NUM_EVENTS-1:0] event_in,
    input  logic                  snap_req,
    output logic                  snap_valid,
    input  logic [SEL_W-1:0]      rd_sel,
    output logic [CNT_W-1:0]      rd_data,
    output logic [NUM_EVENTS:0]   ovf,
    output logic [1:0]            state
);

    localparam int NCNT = NUM_EVENTS + 1;

    logic [1:0]       state_q, state_d;
    logic             snap_valid_q, snap_valid_d;
    logic [CNT_W-1:0] shadow_q [NCNT];
    logic [CNT_W-1:0] shadow_d [NCNT];
    logic [CNT_W-1:0] cnt_nxt  [NCNT];
    logic [NCNT-1:0]  inc_vec;
    logic             run;

    assign run     = (state_q == ST_RUN);
    assign inc_vec = {event_in, 1'b1};

    for (genvar g = 0; g < NCNT; g++) begin : g_cnt
        perf_counter #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE)
        ) u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr_i     (clr),
            .run_i     (run),
            .inc_i     (inc_vec[g]),
            .cnt_nxt_o (cnt_nxt[g]),
            .ovf_o     (ovf[g])
        );
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (start) state_d = ST_RUN;
                ST_RUN:    if (halt)  state_d = ST_FROZEN;
                ST_FROZEN: state_d = ST_FROZEN;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        snap_valid_d = snap_valid_q;
        for (int i = 0; i < NCNT; i++) shadow_d[i] = shadow_q[i];
        if (clr) begin
            snap_valid_d = 1'b0;
            for (int i = 0; i < NCNT; i++) shadow_d[i] = '0;
        end else if (snap_req) begin
            snap_valid_d = 1'b1;
            for (int i = 0; i < NCNT; i++) shadow_d[i] = cnt_nxt[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            snap_valid_q <= 1'b0;
            for (int i = 0; i < NCNT; i++) shadow_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            snap_valid_q <= snap_valid_d;
            for (int i = 0; i < NCNT; i++) shadow_q[i] <= shadow_d[i];
        end
    end

    // Selects beyond the last channel fall through to zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NCNT; i++) begin
            if (rd_sel == SEL_W'(i)) rd_data = shadow_q[i];
        end
    end

    assign snap_valid = snap_valid_q;
    assign state      = state_q;

endmodule
